conv_kernel_engine: RTL and testbench

Parametrised, streaming K×K convolution engine that replaces the fixed 3×3 box-filter processing element in the image filter chain. Rows of K pixels enter through a valid/ready handshake and shift upward through a K×K window. Runtime-loadable signed coefficients are applied to the window through a 3-stage MAC pipeline, followed by rounding and unsigned saturation. The evicted top row is exposed so that engines can be cascaded, and backpressure stalls the whole pipeline without losing data.

---
 rtl/conv_pkg.sv | 46 ++++
 rtl/conv_mac_row.sv | 59 +++++
 rtl/conv_kernel_engine.sv | 156 +++++++++++++++
 tb/tb_conv_kernel_engine.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared helpers and widths for the KxK convolution engine.
package conv_pkg;

    // Ceiling log2, with clog2(1) == 0
    function automatic int clog2(input int v);
        int x;
        int r;
        x = v - 1;
        r = 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // Product of a zero-extended pixel and a signed coefficient
    function automatic int prod_w(input int iw, input int cw);
        return iw + cw + 1;
    endfunction

    // Sum of K products within one window row
    function automatic int row_w(input int iw, input int cw, input int k);
        return prod_w(iw, cw) + clog2(k);
    endfunction

    // Sum of K row sums over the whole window
    function automatic int sum_w(input int iw, input int cw, input int k);
        return row_w(iw, cw, k) + clog2(k);
    endfunction

    // Coefficient index of window tap (r, c); r = 0 is the top row
    function automatic int tap_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

    localparam int DEF_INPUT_WIDTH = 8;
    localparam int DEF_COEF_WIDTH  = 24;
    localparam int DEF_KERNEL      = 3;
    localparam int COEF_RESET_DEF  = 116509;  // ~1/9 in Q20

    localparam int PROD_W = prod_w(DEF_INPUT_WIDTH, DEF_COEF_WIDTH);
    localparam int ROW_W  = row_w(DEF_INPUT_WIDTH, DEF_COEF_WIDTH, DEF_KERNEL);
    localparam int SUM_W  = sum_w(DEF_INPUT_WIDTH, DEF_COEF_WIDTH, DEF_KERNEL);

endpackage

// File: rtl/conv_mac_row.sv
// One window row: K multipliers registered as S1, then the row adder registered as S2.
module conv_mac_row
    import conv_pkg::*;
#(
    parameter int INPUT_WIDTH = 8,
    parameter int COEF_WIDTH  = 24,
    parameter int KERNEL      = 3,
    localparam int PW = prod_w(INPUT_WIDTH, COEF_WIDTH),
    localparam int RW = row_w(INPUT_WIDTH, COEF_WIDTH, KERNEL)
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                en,
    input  logic [KERNEL*INPUT_WIDTH-1:0]       pix,
    input  logic [KERNEL-1:0][COEF_WIDTH-1:0]   coef,
    output logic signed [RW-1:0]                row_sum
);

    logic [KERNEL-1:0][PW-1:0] prod_q, prod_d;
    logic [RW-1:0]             row_q, row_d;

    // S1: zero-extended pixel times signed coefficient, one product per column
    always_comb begin
        prod_d = prod_q;
        if (en) begin
            for (int c = 0; c < KERNEL; c++) begin
                prod_d[c] = PW'($signed({1'b0, pix[c*INPUT_WIDTH +: INPUT_WIDTH]}))
                          * PW'($signed(coef[c]));
            end
        end
    end

    // S2: sign-extended sum of the registered products
    always_comb begin
        logic signed [RW-1:0] acc;
        acc   = '0;
        row_d = row_q;
        if (en) begin
            for (int c = 0; c < KERNEL; c++) begin
                acc = acc + RW'($signed(prod_q[c]));
            end
            row_d = acc;
        end
    end

    // Stage registers; everything holds while the engine is stalled
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prod_q <= '0;
            row_q  <= '0;
        end else begin
            prod_q <= prod_d;
            row_q  <= row_d;
        end
    end

    assign row_sum = $signed(row_q);

endmodule

// File: rtl/conv_kernel_engine.sv
// Streaming KxK convolution: row window, coefficient bank, 3-stage MAC pipe,
// rounding and unsigned saturation, with whole-pipe backpressure.
module conv_kernel_engine
    import conv_pkg::*;
#(
    parameter int INPUT_WIDTH     = 8,
    parameter int RESULT_WIDTH    = 8,
    parameter int KERNEL          = 3,
    parameter int COEF_WIDTH      = 24,
    parameter int COEF_FRACT_BITS = 20,
    parameter int COEF_RESET      = COEF_RESET_DEF
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_sof,
    input  logic [KERNEL*INPUT_WIDTH-1:0]       row_in,
    output logic [KERNEL*INPUT_WIDTH-1:0]       top_row_out,
    input  logic                                coef_we,
    input  logic [clog2(KERNEL*KERNEL)-1:0]     coef_addr,
    input  logic [COEF_WIDTH-1:0]               coef_wdata,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [RESULT_WIDTH-1:0]             out_data,
    output logic                                out_sat
);

    localparam int KK      = KERNEL * KERNEL;
    localparam int ROWBITS = KERNEL * INPUT_WIDTH;
    localparam int RW      = row_w(INPUT_WIDTH, COEF_WIDTH, KERNEL);
    localparam int TW      = sum_w(INPUT_WIDTH, COEF_WIDTH, KERNEL) + 1;  // room for the rounding add
    localparam int FW      = (KERNEL > 1) ? clog2(KERNEL) : 1;
    localparam logic [TW-1:0] HALF = TW'(1) << (COEF_FRACT_BITS - 1);

    logic                                stall, accept, complete;
    logic [KERNEL-1:0][ROWBITS-1:0]      win_q, win_d;
    logic [FW-1:0]                       fill_q, fill_d;
    logic [KK-1:0][COEF_WIDTH-1:0]       coef_q, coef_d;
    // [0] window token, [1] S1, [2] S2, [3] result register
    logic [3:0]                          vld_pipe_q, vld_pipe_d;
    logic [RESULT_WIDTH-1:0]             out_data_q, out_data_d;
    logic                                out_sat_q, out_sat_d;
    logic [KERNEL-1:0][RW-1:0]           row_sum;
    logic signed [TW-1:0]                total, rounded, shifted;
    logic [RESULT_WIDTH-1:0]             res_clip;
    logic                                res_sat;

    assign stall    = vld_pipe_q[3] && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;
    // Only a window fully inside the current frame produces a result
    assign complete = (KERNEL == 1) || (!in_sof && fill_q == FW'(KERNEL - 1));

    // Shift an accepted row in at the bottom and track rows present in this frame
    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        if (accept) begin
            for (int r = 0; r < KERNEL - 1; r++) begin
                win_d[r] = win_q[r + 1];
            end
            win_d[KERNEL - 1] = row_in;
            if (in_sof) begin
                fill_d = FW'(1);
            end else if (fill_q != FW'(KERNEL - 1)) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    // Token/bubble pipe; a non-complete accept or an idle cycle injects a bubble
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        if (!stall) begin
            vld_pipe_d = {vld_pipe_q[2:0], accept && complete};
        end
    end

    // Coefficient writes land regardless of stall; out-of-range taps are dropped
    always_comb begin
        coef_d = coef_q;
        if (coef_we && (32'(coef_addr) < KK)) begin
            coef_d[coef_addr] = coef_wdata;
        end
    end

    for (genvar r = 0; r < KERNEL; r++) begin : g_row
        conv_mac_row #(
            .INPUT_WIDTH (INPUT_WIDTH),
            .COEF_WIDTH  (COEF_WIDTH),
            .KERNEL      (KERNEL)
        ) u_row (
            .clk     (clk),
            .resetn  (resetn),
            .en      (!stall),
            .pix     (win_q[r]),
            .coef    (coef_q[tap_idx(r, 0, KERNEL) +: KERNEL]),
            .row_sum (row_sum[r])
        );
    end

    // S3 datapath: total, round half up, drop fraction, clip to unsigned range
    always_comb begin
        total = '0;
        for (int r = 0; r < KERNEL; r++) begin
            total = total + TW'($signed(row_sum[r]));
        end
        rounded  = total + $signed(HALF);
        shifted  = rounded >>> COEF_FRACT_BITS;
        res_clip = shifted[RESULT_WIDTH-1:0];
        res_sat  = 1'b0;
        if (shifted[TW-1]) begin
            res_clip = '0;
            res_sat  = 1'b1;
        end else if (|shifted[TW-2:RESULT_WIDTH]) begin
            res_clip = '1;
            res_sat  = 1'b1;
        end
    end

    // Result register only loads real tokens so out_data is stable across bubbles and stalls
    always_comb begin
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (!stall && vld_pipe_q[2]) begin
            out_data_d = res_clip;
            out_sat_d  = res_sat;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            win_q      <= '0;
            fill_q     <= '0;
            coef_q     <= {KK{COEF_WIDTH'(COEF_RESET)}};
            vld_pipe_q <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            win_q      <= win_d;
            fill_q     <= fill_d;
            coef_q     <= coef_d;
            vld_pipe_q <= vld_pipe_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign top_row_out = win_q[0];
    assign out_valid   = vld_pipe_q[3];
    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;

endmodule

// File: tb/tb_conv_kernel_engine.sv
// Self-checking bench for conv_kernel_engine (K=3, 8-bit pixels, Q20 coefficients).
module tb_conv_kernel_engine;

    localparam int IW = 8;
    localparam int K  = 3;
    localparam int KK = 9;
    localparam int CW = 24;
    localparam int F  = 20;
    localparam int RB = K * IW;
    localparam int AW = 4;
    localparam int CRESET = 116509;

    logic          clk = 1'b0;
    logic          resetn, in_valid, in_ready, in_sof, coef_we, out_valid, out_ready, out_sat;
    logic [RB-1:0] row_in, top_row_out;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_wdata;
    logic [7:0]    out_data;

    typedef struct { int data; bit sat; } res_t;
    res_t   exp_q[$];
    res_t   got_q[$];
    int     m_win[K][K];
    longint m_coef[KK];
    int     m_fill;
    int     n_pass = 0;
    int     n_total = 0;

    conv_kernel_engine dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .row_in(row_in), .top_row_out(top_row_out),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    // Record every completed output handshake
    always @(negedge clk) begin
        res_t t;
        if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            t.data = int'(out_data);
            t.sat  = out_sat;
            got_q.push_back(t);
        end
    end

    function automatic logic [RB-1:0] mk_row(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) m_win[r][c] = 0;
        for (int i = 0; i < KK; i++) m_coef[i] = CRESET;
        m_fill = 0;
        exp_q.delete();
        got_q.delete();
    endfunction

    function automatic logic [RB-1:0] model_top();
        logic [RB-1:0] t;
        t = '0;
        for (int c = 0; c < K; c++) t[c*IW +: IW] = 8'(m_win[0][c]);
        return t;
    endfunction

    // Window of the last K rows; a full in-frame window yields the rounded, clipped dot product
    function automatic void model_accept(input logic [RB-1:0] row, input bit sof);
        bit     full;
        longint acc, q;
        res_t   e;
        full = !sof && (m_fill == K - 1);
        for (int r = 0; r < K - 1; r++) for (int c = 0; c < K; c++) m_win[r][c] = m_win[r+1][c];
        for (int c = 0; c < K; c++) m_win[K-1][c] = int'(row[c*IW +: IW]);
        if (sof) m_fill = 1;
        else if (m_fill < K - 1) m_fill++;
        if (full) begin
            acc = 0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    acc += longint'(m_win[r][c]) * m_coef[r*K + c];
            q = (acc + (longint'(1) << (F - 1))) >>> F;
            if (q < 0) begin e.data = 0; e.sat = 1; end
            else if (q > 255) begin e.data = 255; e.sat = 1; end
            else begin e.data = int'(q); e.sat = 0; end
            exp_q.push_back(e);
        end
    endfunction

    task automatic cyc(input bit v, input bit s, input logic [RB-1:0] row, input bit o);
        in_valid = v; in_sof = s; row_in = row; out_ready = o;
        @(negedge clk);
        if (v && in_ready) model_accept(row, s);
        @(posedge clk); #1;
    endtask

    task automatic write_coef(input int addr, input int val);
        in_valid = 0; coef_we = 1; coef_addr = 4'(addr); coef_wdata = 24'(val);
        @(posedge clk); #1;
        coef_we = 0;
        if (addr < KK) m_coef[addr] = val;
    endtask

    task automatic drain();
        repeat (6) cyc(0, 0, '0, 1);
    endtask

    function automatic logic [RB-1:0] rnd_row();
        return mk_row($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    endfunction

    task automatic test_reset();
        resetn = 0; in_valid = 0; in_sof = 0; row_in = '0; out_ready = 1;
        coef_we = 0; coef_addr = '0; coef_wdata = '0;
        repeat (2) @(posedge clk);
        #1; resetn = 1; model_reset();
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 8'd0) $display("FAIL reset_out_data: got %0d expected 0", out_data); else n_pass++;
        n_total++; if (out_sat !== 1'b0) $display("FAIL reset_out_sat: got %b expected 0", out_sat); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_total++; if (top_row_out !== '0) $display("FAIL reset_top_row: got %h expected 0", top_row_out); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        cyc(1, 1, mk_row(90, 90, 90), 1);
        cyc(1, 0, mk_row(90, 90, 90), 1);
        in_valid = 1; in_sof = 0; row_in = mk_row(90, 90, 90);
        @(negedge clk);
        if (in_ready) model_accept(row_in, 0);
        @(posedge clk); #1;
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if (out_valid !== (i == 3)) $display("FAIL latency_valid_c%0d: got %b expected %b", i + 1, out_valid, (i == 3));
            else n_pass++;
            if (i == 3) begin
                n_total++; if (out_data !== 8'd90 || out_sat !== 1'b0) $display("FAIL latency_data: got %0d/%b expected 90/0", out_data, out_sat); else n_pass++;
            end
            @(posedge clk); #1;
        end
        drain();
        n_total++; if (got_q.size() !== 1) $display("FAIL latency_count: got %0d expected 1", got_q.size()); else n_pass++;
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_centre_tap();
        for (int i = 0; i < KK; i++) write_coef(i, (i == 4) ? 1048576 : 0);
        write_coef(9, 5000000);  // beyond the last tap: must be ignored
        cyc(1, 1, mk_row(1, 2, 3), 1);
        cyc(1, 0, mk_row(4, 5, 6), 1);
        cyc(1, 0, mk_row(7, 8, 9), 1);
        drain();
        n_total++; if (top_row_out !== mk_row(1, 2, 3)) $display("FAIL centre_top_row: got %h expected %h", top_row_out, mk_row(1, 2, 3)); else n_pass++;
        n_total++;
        if (got_q.size() !== 1 || got_q[0].data !== 5 || got_q[0].sat !== 1'b0)
            $display("FAIL centre_result: got %0d items first %0d expected one item 5", got_q.size(), (got_q.size() > 0) ? got_q[0].data : -1);
        else n_pass++;
        n_total++;
        if (exp_q.size() !== 1 || exp_q[0].data !== 5) $display("FAIL centre_model: got %0d items expected 1", exp_q.size()); else n_pass++;
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < KK; i++) write_coef(i, -1048576);
        cyc(1, 1, mk_row(50, 50, 50), 1);
        cyc(1, 0, mk_row(50, 50, 50), 1);
        cyc(1, 0, mk_row(50, 50, 50), 1);
        drain();
        n_total++;
        if (got_q.size() !== 1 || got_q[0].data !== 0 || got_q[0].sat !== 1'b1)
            $display("FAIL sat_low: got %0d items first %0d expected one item 0 sat", got_q.size(), (got_q.size() > 0) ? got_q[0].data : -1);
        else n_pass++;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < KK; i++) write_coef(i, (i == 4) ? 8388607 : 0);
        cyc(1, 1, mk_row(255, 255, 255), 1);
        cyc(1, 0, mk_row(255, 255, 255), 1);
        cyc(1, 0, mk_row(255, 255, 255), 1);
        drain();
        n_total++;
        if (got_q.size() !== 1 || got_q[0].data !== 255 || got_q[0].sat !== 1'b1)
            $display("FAIL sat_high: got %0d items first %0d expected one item 255 sat", got_q.size(), (got_q.size() > 0) ? got_q[0].data : -1);
        else n_pass++;
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_stall();
        logic [7:0] held;
        held = '0;
        for (int i = 0; i < KK; i++) write_coef(i, int'($urandom_range(0, 2 ** 19)) - 2 ** 18);
        cyc(1, 1, rnd_row(), 1);
        for (int i = 0; i < 7; i++) cyc(1, 0, rnd_row(), 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_sof = 0; row_in = rnd_row(); out_ready = 0;
            @(negedge clk);
            if (i == 0) held = out_data;
            n_total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held)
                $display("FAIL stall_hold_c%0d: got rdy=%b vld=%b data=%0d expected rdy=0 vld=1 data=%0d", i, in_ready, out_valid, out_data, held);
            else n_pass++;
            if (in_ready) model_accept(row_in, 0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) cyc(1, 0, rnd_row(), 1);
        drain();
        n_total++; if (got_q.size() !== exp_q.size()) $display("FAIL stall_count: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].sat !== exp_q[i].sat)
                $display("FAIL stall_item%0d: got %0d/%b expected %0d/%b", i, got_q[i].data, got_q[i].sat, exp_q[i].data, exp_q[i].sat);
            else n_pass++;
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_sof_midstream();
        cyc(1, 1, rnd_row(), 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, rnd_row(), 1);
        cyc(1, 1, rnd_row(), 1);
        cyc(1, 0, rnd_row(), 1);
        cyc(1, 0, rnd_row(), 1);
        drain();
        n_total++; if (got_q.size() !== 3) $display("FAIL sof_count: got %0d expected 3", got_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].sat !== exp_q[i].sat)
                $display("FAIL sof_item%0d: got %0d/%b expected %0d/%b", i, got_q[i].data, got_q[i].sat, exp_q[i].data, exp_q[i].sat);
            else n_pass++;
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit v, s, o;
        logic [RB-1:0] row;
        for (int i = 0; i < KK; i++) write_coef(i, int'($urandom_range(0, 2 ** 19)) - 2 ** 18);
        write_coef($urandom_range(9, 15), int'($urandom_range(0, 2 ** 22)));
        for (int n = 0; n < 300; n++) begin
            v = ($urandom_range(0, 3) != 0);
            s = (n == 0) || ($urandom_range(0, 15) == 0);
            o = ($urandom_range(0, 3) != 0);
            row = rnd_row();
            in_valid = v; in_sof = s; row_in = row; out_ready = o;
            @(negedge clk);
            n_total++;
            if (top_row_out !== model_top()) $display("FAIL rand_top_row_c%0d: got %h expected %h", n, top_row_out, model_top());
            else n_pass++;
            if (v && in_ready) model_accept(row, s);
            @(posedge clk); #1;
        end
        drain();
        n_total++; if (got_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].sat !== exp_q[i].sat)
                $display("FAIL rand_item%0d: got %0d/%b expected %0d/%b", i, got_q[i].data, got_q[i].sat, exp_q[i].data, exp_q[i].sat);
            else n_pass++;
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midstream();
        cyc(1, 1, rnd_row(), 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, rnd_row(), 1);
        n_total++; if (got_q.size() > exp_q.size()) $display("FAIL rst_pre_count: got %0d expected at most %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].sat !== exp_q[i].sat)
                $display("FAIL rst_pre_item%0d: got %0d/%b expected %0d/%b", i, got_q[i].data, got_q[i].sat, exp_q[i].data, exp_q[i].sat);
            else n_pass++;
        end
        resetn = 0; in_valid = 0; in_sof = 0;
        @(posedge clk); #1;
        resetn = 1; model_reset();
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 8'd0 || out_sat !== 1'b0) $display("FAIL rst_out_data: got %0d/%b expected 0/0", out_data, out_sat); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_total++; if (top_row_out !== '0) $display("FAIL rst_top_row: got %h expected 0", top_row_out); else n_pass++;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) cyc(1, 0, mk_row(90, 90, 90), 1);
        drain();
        n_total++;
        if (got_q.size() !== 1 || got_q[0].data !== 90 || got_q[0].sat !== 1'b0)
            $display("FAIL rst_after: got %0d items first %0d expected one item 90", got_q.size(), (got_q.size() > 0) ? got_q[0].data : -1);
        else n_pass++;
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_centre_tap();
        test_saturation();
        test_stall();
        test_sof_midstream();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
